julia_worker_param: RTL and testbench

//  Parametrised fractal pixel worker; successor to the fixed-format Julia worker.
//  - Accepts one pixel coordinate (x,y) from the work dispatcher.
//  - Maps it to the complex plane and iterates z <- z^2 + c, one iteration per clock.
//  - Returns a PIXEL_BITS colour index to the memory controller (MC) via a done/busy handshake.
//  - New over the previous worker: runtime Julia/Mandelbrot mode, parametrised fixed-point format,

---
 rtl/fractal_pkg.sv | 47 ++++
 rtl/fixed_mul_sat.sv | 33 +++
 rtl/julia_worker_param.sv | 160 ++++++++++++++++
 tb/tb_julia_worker_param.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fractal_pkg.sv
// Shared types and saturating fixed-point helpers for the fractal pixel workers.
// Arithmetic is carried in a 64-bit signed word and clipped to the caller's width.
package fractal_pkg;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        ITER,
        DONE
    } worker_state_t;

    localparam int unsigned WIDE_BITS = 64;

    typedef logic signed [WIDE_BITS-1:0] wide_t;

    typedef struct packed {
        logic  ovf;
        wide_t val;
    } sat_res_t;

    // a + b clipped to a w-bit signed range; ovf flags any clipping
    function automatic sat_res_t sat_add(input wide_t a, input wide_t b, input int unsigned w);
        wide_t    sum;
        wide_t    hi;
        wide_t    lo;
        sat_res_t r;
        sum   = a + b;
        hi    = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo    = -(wide_t'(1) <<< (w - 1));
        r.ovf = 1'b0;
        r.val = sum;
        if (sum > hi) begin
            r.ovf = 1'b1;
            r.val = hi;
        end else if (sum < lo) begin
            r.ovf = 1'b1;
            r.val = lo;
        end
        return r;
    endfunction

    // |z|^2 escape threshold (4.0) in the unshifted product scale
    function automatic wide_t escape_limit(input int unsigned frac);
        return wide_t'(4) <<< (2 * frac);
    endfunction

endpackage

// File: rtl/fixed_mul_sat.sv
// Signed fixed-point multiply: floor shift by FRAC, saturate to WIDTH bits.
// The raw full-precision product is exported for the magnitude compare.
module fixed_mul_sat #(
    parameter int WIDTH = 22,
    parameter int FRAC  = 11
) (
    input  logic signed [WIDTH-1:0]   a,
    input  logic signed [WIDTH-1:0]   b,
    output logic signed [WIDTH-1:0]   p,
    output logic signed [2*WIDTH-1:0] raw,
    output logic                      ovf
);

    logic signed [2*WIDTH-1:0] prod;
    logic signed [2*WIDTH-1:0] shifted;
    logic        [WIDTH:0]     top;

    assign prod    = a * b;
    assign shifted = prod >>> FRAC;
    assign raw     = prod;

    // in range only when every bit above the result sign matches it
    assign top = shifted[2*WIDTH-1:WIDTH-1];
    assign ovf = !((&top) || !(|top));

    always_comb begin
        p = shifted[WIDTH-1:0];
        if (ovf) begin
            p = shifted[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

endmodule

// File: rtl/julia_worker_param.sv
// Parametrised Julia/Mandelbrot pixel worker: one z <- z^2 + c iteration per clock,
// colour index returned to the memory controller over a done/busy handshake.
module julia_worker_param
    import fractal_pkg::*;
#(
    parameter int WIDTH       = 22,
    parameter int FRAC        = 11,
    parameter int MAX_ITER    = 256,
    parameter int PIXEL_BITS  = 8,
    parameter int COORD_BITS  = 10,
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int SCALE_SHIFT = 8
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [COORD_BITS-1:0] x,
    input  logic [COORD_BITS-1:0] y,
    input  logic                  mode,
    input  logic [WIDTH-1:0]      c_real_in,
    input  logic [WIDTH-1:0]      c_imag_in,
    input  logic                  JW_start,
    input  logic                  MC_busy,
    output logic                  JW_ready,
    output logic                  JW_done,
    output logic [PIXEL_BITS-1:0] pixel
);

    localparam int unsigned N_BITS    = $clog2(MAX_ITER);
    localparam int unsigned PIX_SHIFT = N_BITS - PIXEL_BITS;
    localparam logic [N_BITS-1:0]     N_LAST      = N_BITS'(MAX_ITER - 1);
    localparam logic [PIXEL_BITS-1:0] PIX_ESC_MAX = {{(PIXEL_BITS-1){1'b1}}, 1'b0};

    worker_state_t state, state_d;

    logic [COORD_BITS-1:0]   x_q, y_q;
    logic                    mode_q;
    logic signed [WIDTH-1:0] cr_in_q, ci_in_q;
    logic signed [WIDTH-1:0] zr, zi, cr, ci;
    logic [N_BITS-1:0]       n;
    logic                    sat;
    logic [PIXEL_BITS-1:0]   pixel_q;

    logic signed [WIDTH-1:0]   rr, ii, ri;
    logic signed [2*WIDTH-1:0] rr_raw, ii_raw, ri_raw;
    logic                      rr_ovf, ii_ovf, ri_ovf;

    sat_res_t pr_res, pi_res, zr_diff, zr_next, zi_dbl, zi_next;
    logic signed [WIDTH-1:0] pr, pi;
    wide_t                   mag;
    logic                    escape, upd_ovf;
    logic [N_BITS-1:0]       n_scaled;
    logic [PIXEL_BITS-1:0]   esc_pix;

    fixed_mul_sat #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_rr (
        .a(zr), .b(zr), .p(rr), .raw(rr_raw), .ovf(rr_ovf)
    );
    fixed_mul_sat #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_ii (
        .a(zi), .b(zi), .p(ii), .raw(ii_raw), .ovf(ii_ovf)
    );
    fixed_mul_sat #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_ri (
        .a(zr), .b(zi), .p(ri), .raw(ri_raw), .ovf(ri_ovf)
    );

    always_comb begin
        pr_res = sat_add((wide_t'(x_q) - wide_t'(H_RES / 2)) <<< (FRAC - SCALE_SHIFT), '0, WIDTH);
        pi_res = sat_add((wide_t'(y_q) - wide_t'(V_RES / 2)) <<< (FRAC - SCALE_SHIFT), '0, WIDTH);
        pr     = WIDTH'(pr_res.val);
        pi     = WIDTH'(pi_res.val);

        mag     = wide_t'(rr_raw) + wide_t'(ii_raw);
        escape  = (mag > escape_limit(FRAC)) || sat;
        zr_diff = sat_add(wide_t'(rr), -wide_t'(ii), WIDTH);
        zr_next = sat_add(zr_diff.val, wide_t'(cr), WIDTH);
        zi_dbl  = sat_add(wide_t'(ri), wide_t'(ri), WIDTH);
        zi_next = sat_add(zi_dbl.val, wide_t'(ci), WIDTH);
        upd_ovf = rr_ovf | ii_ovf | ri_ovf | zr_diff.ovf | zr_next.ovf | zi_dbl.ovf | zi_next.ovf;

        n_scaled = n >> PIX_SHIFT;
        esc_pix  = (n_scaled >= N_BITS'(PIX_ESC_MAX)) ? PIX_ESC_MAX : PIXEL_BITS'(n_scaled);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (JW_start) state_d = INIT;
            INIT:    state_d = ITER;
            ITER:    if (escape || n == N_LAST) state_d = DONE;
            DONE:    if (!MC_busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            x_q     <= '0;
            y_q     <= '0;
            mode_q  <= 1'b0;
            cr_in_q <= '0;
            ci_in_q <= '0;
            zr      <= '0;
            zi      <= '0;
            cr      <= '0;
            ci      <= '0;
            n       <= '0;
            sat     <= 1'b0;
            pixel_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (JW_start) begin
                        x_q     <= x;
                        y_q     <= y;
                        mode_q  <= mode;
                        cr_in_q <= c_real_in;
                        ci_in_q <= c_imag_in;
                    end
                end
                INIT: begin
                    n   <= '0;
                    sat <= pr_res.ovf | pi_res.ovf;
                    if (mode_q) begin
                        zr <= '0;
                        zi <= '0;
                        cr <= pr;
                        ci <= pi;
                    end else begin
                        zr <= pr;
                        zi <= pi;
                        cr <= cr_in_q;
                        ci <= ci_in_q;
                    end
                end
                ITER: begin
                    if (escape) begin
                        pixel_q <= esc_pix;
                    end else if (n == N_LAST) begin
                        pixel_q <= '1;
                    end else begin
                        zr  <= WIDTH'(zr_next.val);
                        zi  <= WIDTH'(zi_next.val);
                        n   <= n + 1'b1;
                        sat <= sat | upd_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

    assign JW_ready = (state == IDLE);
    assign JW_done  = (state == DONE);
    assign pixel    = pixel_q;

endmodule

// File: tb/tb_julia_worker_param.sv
// Scoreboard bench: stimulus pushes the expected pixel and done cycle, monitors pop
// and compare on each rising JW_done. A second, narrow instance covers saturation.
module tb_julia_worker_param;

    typedef struct {
        logic [7:0] pix;
        int         done_cyc;
    } exp_t;

    logic tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    logic        n_rst;
    logic [9:0]  x, y;
    logic        mode;
    logic [21:0] c_real_in, c_imag_in;
    logic        JW_start, MC_busy;
    logic        JW_ready, JW_done;
    logic [7:0]  pixel;

    logic [11:0] s_c_real, s_c_imag;
    logic        s_start, s_busy, s_ready, s_done;
    logic [7:0]  s_pixel;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t exp_q[$];
    exp_t exp_s[$];
    logic done_prev = 1'b0;
    logic s_done_prev = 1'b0;

    julia_worker_param dut (
        .clk(tb_clk), .n_rst(n_rst), .x(x), .y(y), .mode(mode),
        .c_real_in(c_real_in), .c_imag_in(c_imag_in),
        .JW_start(JW_start), .MC_busy(MC_busy),
        .JW_ready(JW_ready), .JW_done(JW_done), .pixel(pixel)
    );

    julia_worker_param #(.WIDTH(12)) dut_s (
        .clk(tb_clk), .n_rst(n_rst), .x(x), .y(y), .mode(mode),
        .c_real_in(s_c_real), .c_imag_in(s_c_imag),
        .JW_start(s_start), .MC_busy(s_busy),
        .JW_ready(s_ready), .JW_done(s_done), .pixel(s_pixel)
    );

    always @(posedge tb_clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic timeout(input string name);
        n_checks++;
        $display("FAIL %s: got timeout, expected event", name);
    endtask

    always @(negedge tb_clk) begin : mon_main
        exp_t e;
        if (JW_done && !done_prev) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: got pixel %0d, expected no result", pixel);
            end else begin
                e = exp_q.pop_front();
                check("pixel", pixel, e.pix);
                check("done_cycle", cyc, e.done_cyc);
            end
        end
        done_prev = JW_done;
    end

    always @(negedge tb_clk) begin : mon_small
        exp_t e;
        if (s_done && !s_done_prev) begin
            if (exp_s.size() == 0) begin
                n_checks++;
                $display("FAIL s_unexpected_done: got pixel %0d, expected no result", s_pixel);
            end else begin
                e = exp_s.pop_front();
                check("s_pixel", s_pixel, e.pix);
                check("s_done_cycle", cyc, e.done_cyc);
            end
        end
        s_done_prev = s_done;
    end

    task automatic wait_ready();
        for (int t = 0; t < 50 && !JW_ready; t++) @(negedge tb_clk);
        if (!JW_ready) timeout("wait_ready");
    endtask

    task automatic wait_done();
        for (int t = 0; t < 400 && !JW_done; t++) @(negedge tb_clk);
        if (!JW_done) timeout("wait_done");
    endtask

    task automatic run_job(input logic [9:0] xi, input logic [9:0] yi, input logic m,
                           input logic [21:0] cri, input logic [21:0] cii,
                           input logic [7:0] ep, input int lat, input int hold,
                           input logic busy0);
        wait_ready();
        x = xi; y = yi; mode = m; c_real_in = cri; c_imag_in = cii;
        MC_busy  = !busy0;
        JW_start = 1'b1;
        exp_q.push_back('{ep, cyc + 1 + lat});
        @(negedge tb_clk);
        JW_start = 1'b0;
        wait_done();
        for (int h = 0; h < hold; h++) begin
            @(negedge tb_clk);
            check("hold_done", JW_done, 1);
            check("hold_pixel", pixel, ep);
        end
        MC_busy = 1'b0;
        @(negedge tb_clk);
        check("release_done", JW_done, 0);
        check("release_ready", JW_ready, 1);
    endtask

    initial begin
        n_rst = 1'b0; x = '0; y = '0; mode = 1'b0;
        c_real_in = '0; c_imag_in = '0; JW_start = 1'b0; MC_busy = 1'b1;
        s_c_real = '0; s_c_imag = '0; s_start = 1'b0; s_busy = 1'b1;
        repeat (3) @(negedge tb_clk);
        check("rst_ready", JW_ready, 1);
        check("rst_done", JW_done, 0);
        check("rst_pixel", pixel, 0);
        check("rst_s_ready", s_ready, 1);
        n_rst = 1'b1;
        @(negedge tb_clk);

        // in-set origin, escape at n=1, Mandelbrot c=1 escape at n=3, busy low on entry
        run_job(10'd320, 10'd240, 1'b0, 22'h0, 22'h0, 8'hFF, 257, 3, 1'b0);
        run_job(10'd0,   10'd0,   1'b0, 22'h0, 22'h0, 8'h01, 3,   0, 1'b0);
        run_job(10'd576, 10'd240, 1'b1, 22'h0, 22'h0, 8'h03, 5,   2, 1'b0);
        run_job(10'd0,   10'd0,   1'b0, 22'h0, 22'h0, 8'h01, 3,   0, 1'b1);

        // starts during ITER and DONE must be ignored
        wait_ready();
        x = 10'd576; y = 10'd240; mode = 1'b1; c_real_in = '0; c_imag_in = '0;
        MC_busy = 1'b1; JW_start = 1'b1;
        exp_q.push_back('{8'h03, cyc + 1 + 5});
        @(negedge tb_clk);
        JW_start = 1'b0;
        @(negedge tb_clk);
        x = 10'd0; y = 10'd0; mode = 1'b0; JW_start = 1'b1;
        repeat (2) @(negedge tb_clk);
        JW_start = 1'b0;
        wait_done();
        JW_start = 1'b1;
        repeat (2) @(negedge tb_clk);
        check("ign_done_held", JW_done, 1);
        check("ign_pixel", pixel, 8'h03);
        JW_start = 1'b0; MC_busy = 1'b0;
        @(negedge tb_clk);
        check("ign_release_ready", JW_ready, 1);
        MC_busy = 1'b1;
        repeat (3) @(negedge tb_clk);
        check("ign_not_queued", JW_ready, 1);
        run_job(10'd0, 10'd0, 1'b0, 22'h0, 22'h0, 8'h01, 3, 0, 1'b0);

        // reset mid-ITER aborts with no result
        wait_ready();
        x = 10'd320; y = 10'd240; mode = 1'b0; MC_busy = 1'b1; JW_start = 1'b1;
        @(negedge tb_clk);
        JW_start = 1'b0;
        repeat (20) @(negedge tb_clk);
        #2 n_rst = 1'b0;
        #1;
        check("abort_ready", JW_ready, 1);
        check("abort_done", JW_done, 0);
        check("abort_pixel", pixel, 0);
        #1 n_rst = 1'b1;
        @(negedge tb_clk);
        run_job(10'd576, 10'd240, 1'b1, 22'h0, 22'h0, 8'h03, 5, 0, 1'b0);

        // narrow word: coordinate saturates in INIT, forcing escape at n=0
        x = 10'd639; y = 10'd479; mode = 1'b0;
        s_c_real = 12'hFFF; s_c_imag = 12'hFFF; s_busy = 1'b1;
        check("s_ready_before", s_ready, 1);
        s_start = 1'b1;
        exp_s.push_back('{8'h00, cyc + 1 + 2});
        @(negedge tb_clk);
        s_start = 1'b0;
        for (int t = 0; t < 400 && !s_done; t++) @(negedge tb_clk);
        if (!s_done) timeout("s_wait_done");
        s_busy = 1'b0;
        @(negedge tb_clk);
        check("s_release_ready", s_ready, 1);

        repeat (5) @(negedge tb_clk);
        check("main_queue_empty", exp_q.size(), 0);
        check("small_queue_empty", exp_s.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
